// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
// Contents: transmitter FSM state encoding, parity mode codes, and a
// helper that turns the XOR of the data bits into the framed parity bit.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } uart_state_t;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

   // Even mode sends the XOR of the data bits; odd mode sends its inverse.
   function automatic logic parity_of(input logic xor_bit, input int unsigned mode);
      return (mode == PAR_ODD) ? ~xor_bit : xor_bit;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding the words waiting to be transmitted.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (pointers and count cleared)
//   push      - enqueue wdata; ignored while full
//   pop       - dequeue the head word; ignored while empty
//   wdata     - word to enqueue
//   rdata     - head word, valid combinationally while not empty
//   count     - registered number of stored words
//   full      - registered, count == DEPTH
//   empty     - registered, count == 0
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;
   logic [CNT_W-1:0] count_nxt;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Occupancy after this cycle; a simultaneous push and pop cancel out.
   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop) begin
         count_nxt = count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
         count_nxt = count - CNT_W'(1);
      end
   end

   // Pointers and flags; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count_nxt;
         full  <= (count_nxt == CNT_W'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   // Storage is not reset; stale entries are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter with configurable frame format.
// Words written on to_send/we are queued and sent LSB first as
// start, DATA_W data bits, optional parity, STOP_BITS stop bits,
// each bit lasting CLKS_PER_BIT clocks. Queued frames follow each
// other with no idle gap.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (aborts any frame)
//   to_send   - word to enqueue, sampled only on an accepted write
//   we        - write strobe; dropped while full
//   full      - FIFO full (registered)
//   count     - words held in the FIFO (registered)
//   overflow  - one-cycle pulse the cycle after a dropped write
//   busy      - a frame is on the line
//   tx        - serial output, idles high
module uart_tx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_W-1:0]           to_send,
   input  logic                        we,
   output logic                        full,
   output logic [$clog2(FIFO_DEPTH):0] count,
   output logic                        overflow,
   output logic                        busy,
   output logic                        tx
);

   import uart_pkg::*;

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_W);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

   uart_state_t       state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [IDX_W-1:0]  bit_idx;
   logic [DATA_W-1:0] shift;
   logic              par_bit;

   logic [DATA_W-1:0] fifo_rdata;
   logic              fifo_empty;
   logic              fifo_full;
   logic              push;
   logic              pop;
   logic              bit_end;
   logic              frame_end;

   assign full = fifo_full;
   assign push = we && !fifo_full;

   // Pop from IDLE, or on the last stop-bit cycle so the next start bit
   // follows immediately.
   assign bit_end   = (bit_cnt == CNT_LAST);
   assign frame_end = (state == STOP) && bit_end && (bit_idx == STOP_LAST);
   assign pop       = !fifo_empty && ((state == IDLE) || frame_end);

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (to_send),
      .rdata (fifo_rdata),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Frame sequencer; tx and busy are registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
         par_bit <= 1'b0;
         tx      <= 1'b1;
         busy    <= 1'b0;
      end else if (pop) begin
         shift   <= fifo_rdata;
         par_bit <= parity_of(^fifo_rdata, PARITY);
         bit_cnt <= '0;
         bit_idx <= '0;
         tx      <= 1'b0;
         busy    <= 1'b1;
         state   <= START;
      end else begin
         case (state)
            IDLE: begin
               tx   <= 1'b1;
               busy <= 1'b0;
            end

            START: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  tx      <= shift[0];
                  shift   <= {1'b0, shift[DATA_W-1:1]};
                  state   <= DATA;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end

            DATA: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (bit_idx == DATA_LAST) begin
                     bit_idx <= '0;
                     if (PARITY != PAR_NONE) begin
                        tx    <= par_bit;
                        state <= PAR;
                     end else begin
                        tx    <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                     tx      <= shift[0];
                     shift   <= {1'b0, shift[DATA_W-1:1]};
                  end
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end

            PAR: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  tx      <= 1'b1;
                  state   <= STOP;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end

            STOP: begin
               tx <= 1'b1;
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (bit_idx == STOP_LAST) begin
                     // Queue empty at frame end (a non-empty queue took the pop path).
                     bit_idx <= '0;
                     busy    <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                  end
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end

            default: begin
               tx    <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Flag writes dropped because the FIFO was full at the start of the cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else begin
         overflow <= we && fifo_full;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo. Five instances cover 8N1, 8E1, 8O1,
// 8N2 (CLKS_PER_BIT=4) and 7N1 (CLKS_PER_BIT=3). Stimulus pushes the
// expected per-cycle (tx, busy) stream of the selected instance into a
// queue; a monitor pops one entry per clock and compares.
module tb_uart_tx_fifo;

   localparam int NI = 5;

   typedef struct packed {
      logic tx;
      logic busy;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       we;
   logic [7:0] din;
   int         sel;

   logic       tx_v   [NI];
   logic       busy_v [NI];
   logic       full_v [NI];
   logic       ovf_v  [NI];
   logic [2:0] cnt_v  [NI];

   exp_t exp_q [$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int unsigned CPB = (g == 4) ? 3 : 4;
      localparam int unsigned DW  = (g == 4) ? 7 : 8;
      localparam int unsigned PM  = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
      localparam int unsigned SB  = (g == 3) ? 2 : 1;

      uart_tx_fifo #(
         .CLKS_PER_BIT (CPB),
         .DATA_W       (DW),
         .FIFO_DEPTH   (4),
         .PARITY       (PM),
         .STOP_BITS    (SB)
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .to_send  (din[DW-1:0]),
         .we       (we && (sel == g)),
         .full     (full_v[g]),
         .count    (cnt_v[g]),
         .overflow (ovf_v[g]),
         .busy     (busy_v[g]),
         .tx       (tx_v[g])
      );
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s inst=%0d: got 0x%0h, required 0x%0h", name, sel, act, req);
      end
   endtask

   // Expected line for a frame given LSB-first as bits[0..nbits-1]; limit truncates it.
   task automatic push_frame(input logic [15:0] bits, input int nbits, input int cpb, input int limit);
      exp_t e;
      int   n;
      n = 0;
      for (int i = 0; i < nbits; i++) begin
         for (int c = 0; c < cpb; c++) begin
            if (n < limit) begin
               e.tx   = bits[i];
               e.busy = 1'b1;
               exp_q.push_back(e);
               n++;
            end
         end
      end
   endtask

   task automatic push_idle(input int n);
      exp_t e;
      e.tx   = 1'b1;
      e.busy = 1'b0;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain inst=%0d: %0d expected cycles left, required 0", sel, exp_q.size());
         exp_q.delete();
      end
   endtask

   // One write into an idle instance, then its full frame and a trailing idle.
   task automatic run_frame(input int g, input logic [7:0] data, input logic [15:0] bits,
                            input int nbits, input int cpb);
      sel = g;
      @(negedge clk);
      we  = 1'b1;
      din = data;
      @(negedge clk);
      we  = 1'b0;
      din = ~data;
      push_frame(bits, nbits, cpb, 1000);
      push_idle(4);
      check("cnt_after_write", 8'(cnt_v[g]), 8'd1);
      check("tx_before_start", 8'(tx_v[g]), 8'd1);
      check("busy_before_start", 8'(busy_v[g]), 8'd0);
      wait_drain(200);
   endtask

   // Monitor: one expected (tx, busy) pair per clock while the queue is non-empty.
   initial begin
      forever begin
         exp_t e;
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (tx_v[sel] !== e.tx || busy_v[sel] !== e.busy) begin
               errors++;
               $display("FAIL line inst=%0d t=%0t: tx=%b busy=%b, required tx=%b busy=%b",
                        sel, $time, tx_v[sel], busy_v[sel], e.tx, e.busy);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      we  = 1'b1;
      din = 8'h5A;
      sel = 0;

      // Reset held 3 cycles with a write strobe present.
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
         sel = g;
         check("rst_tx", 8'(tx_v[g]), 8'd1);
         check("rst_busy", 8'(busy_v[g]), 8'd0);
         check("rst_count", 8'(cnt_v[g]), 8'd0);
         check("rst_full", 8'(full_v[g]), 8'd0);
         check("rst_overflow", 8'(ovf_v[g]), 8'd0);
      end
      sel = 0;
      rst = 1'b0;
      we  = 1'b0;
      push_idle(10);
      wait_drain(50);
      check("post_rst_count", 8'(cnt_v[0]), 8'd0);

      // Single frames of 0x45 in each format, then 0x7F in 7N1.
      run_frame(0, 8'h45, 16'b1010001010, 10, 4);
      run_frame(1, 8'h45, 16'b11010001010, 11, 4);
      run_frame(2, 8'h45, 16'b10010001010, 11, 4);
      run_frame(3, 8'h45, 16'b11010001010, 11, 4);
      run_frame(4, 8'h7F, 16'b111111110, 9, 3);

      // Six consecutive writes into a depth-4 FIFO: the sixth is dropped.
      sel = 0;
      for (int k = 1; k <= 6; k++) begin
         we  = 1'b1;
         din = 8'(k);
         @(negedge clk);
         if (k == 1) begin
            for (int f = 1; f <= 5; f++) begin
               push_frame({6'b0, 1'b1, 8'(f), 1'b0}, 10, 4, 1000);
            end
            push_idle(4);
         end
         if (k == 5) begin
            check("ovf_count_peak", 8'(cnt_v[0]), 8'd4);
            check("ovf_full", 8'(full_v[0]), 8'd1);
            check("ovf_not_yet", 8'(ovf_v[0]), 8'd0);
         end
         if (k == 6) begin
            check("ovf_pulse", 8'(ovf_v[0]), 8'd1);
            check("ovf_count_hold", 8'(cnt_v[0]), 8'd4);
         end
      end
      we  = 1'b0;
      din = 8'h00;
      @(negedge clk);
      check("ovf_single", 8'(ovf_v[0]), 8'd0);
      wait_drain(400);

      // Reset during DATA of the first of two queued words.
      @(negedge clk);
      we  = 1'b1;
      din = 8'h11;
      @(negedge clk);
      din = 8'h22;
      push_frame({6'b0, 1'b1, 8'h11, 1'b0}, 10, 4, 11);
      push_idle(20);
      @(negedge clk);
      we  = 1'b0;
      din = 8'h00;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_tx", 8'(tx_v[0]), 8'd1);
      check("midrst_count", 8'(cnt_v[0]), 8'd0);
      check("midrst_busy", 8'(busy_v[0]), 8'd0);
      rst = 1'b0;
      wait_drain(100);

      // A fresh write after the aborted frame.
      run_frame(0, 8'hA5, 16'b1101001010, 10, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised successor to the fixed-format `uart_ctrl` transmitter. It accepts words on a `to_send`/`we` write port into an internal FIFO and serialises them on `tx` with a configurable frame:
- data width
- bit period in clocks
- parity mode
- stop-bit count

It sits between the CPU-side register write path and the board TX pin. Back-to-back frames are sent with no idle gap.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16, clocks per serial bit; legal range ≥ 2.
- `DATA_W`, 8, data bits per frame; legal range 5..9.
- `FIFO_DEPTH`, 4, TX FIFO entries; must be a power of 2, ≥ 2.
- `PARITY`, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1, stop bits per frame; 1 or 2.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `to_send`  in  DATA_W  word to enqueue.
- `we`  in  1  write strobe; one word enqueued per cycle when high and not `full`.
- `full`  out  1  FIFO full; a write in this cycle is dropped.
- `count`  out  $clog2(FIFO_DEPTH)+1  words currently held in the FIFO.
- `overflow`  out  1  one-cycle pulse, registered, in the cycle after a dropped write.
- `busy`  out  1  high while a frame is on the line (FSM not IDLE).
- `tx`  out  1  serial line; idles high.

## Operation
- Reset values:
  - `tx` = 1.
  - `busy`, `overflow`, `full` = 0.
  - `count` = 0.
  - FSM = IDLE.
  - FIFO pointers cleared, so contents are discarded.
- Reset mid-frame aborts the frame; `tx` is 1 from the first edge with `rst` high.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, compute parity, and go to START.
  - START: `tx` = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx` = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. After DATA_W bits, go to PAR if PARITY ≠ 0, else STOP.
  - PAR: `tx` = parity bit for CLKS_PER_BIT cycles, then go to STOP.
    - Even mode: XOR of the data bits.
    - Odd mode: the inverse of that XOR.
  - STOP: `tx` = 1 for STOP_BITS×CLKS_PER_BIT cycles.
    - At the final cycle, if the FIFO is non-empty, pop and go directly to START (zero gap).
    - Otherwise go to IDLE.
- Counters:
  - Bit-period counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit index counter: counts data bits in DATA and stop bits in STOP.
- Frame length = CLKS_PER_BIT × (1 + DATA_W + (PARITY≠0) + STOP_BITS) cycles.
- FIFO rules:
  - Push when `we` && !`full`.
  - Pop is generated only by the FSM.
  - Push and pop in the same cycle leave `count` unchanged.
  - `full` is decoded from `count` before this cycle's pop, so a write while `full` is dropped even if a pop occurs in the same cycle.
  - `overflow` pulses for every dropped write.
- `to_send` is sampled only on an accepted write. Later changes never affect queued data.

## Timing
- Write accepted at edge E0 into an empty FIFO with the FSM in IDLE:
  - Pop at E1; `tx` falls and `busy` rises at E1.
  - Latency from write to start bit: 1 cycle.
- `count`, `full`, `busy` and `tx` are all registered outputs.
- `count` reflects pushes and pops on the edge after they occur.
- Back-to-back frames: the start bit of frame n+1 begins the cycle after the last stop-bit cycle of frame n.
- `busy` stays high across back-to-back frames. It falls on the edge that enters IDLE.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, PAR, STOP).
  - Parity mode constants PAR_NONE = 0, PAR_EVEN = 1, PAR_ODD = 2.
- Sub-module `sync_fifo`:
  - Parameters: WIDTH and DEPTH.
  - Ports: `clk`, `rst`, push, pop, wdata, rdata, `count`, `full`, empty.
  - rdata is the head word and is valid combinationally while not empty.
- Top-level logic: FSM, bit-period counter, bit index counter, shift register, parity generation, overflow register.

## Test plan
- Reset:
  - Hold `rst` for 3 cycles with `we` = 1 → `tx` = 1, `count` = 0, `busy` = 0, no `overflow`, nothing enqueued.
- Single frame (CLKS_PER_BIT = 4, 8N1):
  - Write 69 (0x45) at E0 → `tx` from E1 is: 0 ×4, then 1,0,1,0,0,0,1,0 ×4 each, then 1 ×4.
  - `busy` falls at E1 + 40.
- Parity modes (same setup, byte 0x45):
  - PARITY = 1 → parity bit 1, frame 44 cycles.
  - PARITY = 2 → parity bit 0.
  - STOP_BITS = 2 → stop high for 8 cycles.
- Overflow (FIFO_DEPTH = 4):
  - Write 0x01..0x06 on 6 consecutive cycles → 0x01..0x05 are transmitted back-to-back with no idle cycle between frames.
  - `overflow` pulses once, the cycle after the 6th write.
  - `count` peaks at 4.
- Reset mid-frame:
  - Assert `rst` during DATA of the first of two queued words → `tx` = 1 and `count` = 0 next cycle.
  - No further frame is sent.
  - A new write then produces a complete, correct frame.
- DATA_W = 7, CLKS_PER_BIT = 3:
  - Write 0x7F → 7 data ones, frame length 27 cycles.
